// File: rtl/uart_rx_deserializer.sv
// UART receiver: 8N1 deserializer with stop-bit framing checks and an
// idle-gap end-of-packet detector that arms after each good byte.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int EOP_BITS     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_ready,
  output logic       frame_error,
  output logic       endofpacket,
  output logic       idle
);

  localparam int CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_CYC   = EOP_BITS * CLKS_PER_BIT;
  localparam int GAP_W     = $clog2(GAP_CYC + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(GAP_CYC);
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic             rx_meta_q;
  logic             rxs_q;
  state_e           state_q;
  logic [CNT_W-1:0] clk_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             data_ready_q;
  logic             frame_error_q;
  logic             eop_q;
  logic             idle_q;
  logic             armed_q;
  logic [GAP_W-1:0] gap_q;

  // Synchronizer resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      data_ready_q  <= 1'b0;
      frame_error_q <= 1'b0;
      eop_q         <= 1'b0;
      idle_q        <= 1'b1;
      armed_q       <= 1'b0;
      gap_q         <= '0;
    end else begin
      data_ready_q  <= 1'b0;
      frame_error_q <= 1'b0;
      eop_q         <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            // A new start bit restarts the gap but leaves the detector armed.
            state_q   <= S_START;
            idle_q    <= 1'b0;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            gap_q     <= '0;
          end else if (armed_q) begin
            if (gap_q == GAP_LAST) begin
              gap_q   <= GAP_MAX;
              eop_q   <= 1'b1;
              armed_q <= 1'b0;
            end else begin
              gap_q <= gap_q + GAP_ONE;
            end
          end
        end
        S_START: begin
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= '0;
            if (rxs_q) begin
              state_q <= S_IDLE;
              idle_q  <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            shift_q   <= {rxs_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_ONE;
          end
        end
        S_STOP: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            if (rxs_q) begin
              data_q       <= shift_q;
              data_ready_q <= 1'b1;
              armed_q      <= 1'b1;
              state_q      <= S_IDLE;
              idle_q       <= 1'b1;
            end else begin
              frame_error_q <= 1'b1;
              armed_q       <= 1'b0;
              state_q       <= S_BREAK;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_ONE;
          end
        end
        S_BREAK: begin
          // Line must return high before another frame can begin.
          if (rxs_q) begin
            state_q <= S_IDLE;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  assign data        = data_q;
  assign data_ready  = data_ready_q;
  assign frame_error = frame_error_q;
  assign endofpacket = eop_q;
  assign idle        = idle_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed frames plus a randomized frame
// stream checked against a frame-level reference model.
module tb_uart_rx_deserializer;

  localparam int C    = 16;
  localparam int EB   = 4;
  localparam int LAT  = 2 + C / 2 + 9 * C + 1;
  localparam int GAPC = EB * C;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       data_ready;
  logic       frame_error;
  logic       endofpacket;
  logic       idle;

  uart_rx_deserializer #(.CLKS_PER_BIT(C), .EOP_BITS(EB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .data_ready (data_ready),
    .frame_error(frame_error),
    .endofpacket(endofpacket),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every pulse with the cycle it appeared in.
  int         dr_cyc[$];
  logic [7:0] dr_dat[$];
  int         eop_cyc[$];
  int         fe_cnt = 0;
  int         excl_viol = 0;
  always @(negedge clk) begin
    if (data_ready === 1'b1) begin
      dr_cyc.push_back(cyc);
      dr_dat.push_back(data);
    end
    if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
    if (endofpacket === 1'b1) eop_cyc.push_back(cyc);
    if (int'(data_ready === 1'b1) + int'(frame_error === 1'b1) + int'(endofpacket === 1'b1) > 1)
      excl_viol <= excl_viol + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    tick(C);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  function automatic logic [31:0] get_dat(input int idx);
    if (idx < dr_dat.size()) return {24'h0, dr_dat[idx]};
    return 32'hDEAD;
  endfunction

  function automatic int get_cyc(input int idx);
    if (idx < dr_cyc.size()) return dr_cyc[idx];
    return -100000;
  endfunction

  function automatic logic in_window(input int obs, input int exp);
    return (obs >= exp - 1) && (obs <= exp + 1);
  endfunction

  int dr0, eop0, fe0, t0;

  task automatic snap();
    dr0  = dr_cyc.size();
    eop0 = eop_cyc.size();
    fe0  = fe_cnt;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic [7:0] exp_q[$];
    logic [7:0] last_good;
    int         exp_fe, exp_eop, g, k;
    bit         armed, err;
    int         gaps[6] = '{0, 1, 2, 3, 5, 6};

    // Reset values
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(3);
    check("rst_data", {24'h0, data}, 32'h00);
    check("rst_dr", {31'h0, data_ready}, 32'h0);
    check("rst_fe", {31'h0, frame_error}, 32'h0);
    check("rst_eop", {31'h0, endofpacket}, 32'h0);
    check("rst_idle", {31'h0, idle}, 32'h1);
    rst_n = 1'b1;
    tick(4);

    // Single byte, latency
    snap();
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    tick(6 * C);
    check("a5_cnt", dr_cyc.size() - dr0, 1);
    check("a5_data", get_dat(dr0), 32'hA5);
    check("a5_lat", {31'h0, in_window(get_cyc(dr0) - t0, LAT)}, 32'h1);
    check("a5_fe", fe_cnt - fe0, 0);
    check("a5_out", {24'h0, data}, 32'hA5);

    // Back-to-back frames then idle gap
    snap();
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    tick(6 * C);
    check("b2b_cnt", dr_cyc.size() - dr0, 2);
    check("b2b_d0", get_dat(dr0), 32'h3C);
    check("b2b_d1", get_dat(dr0 + 1), 32'hC3);
    check("b2b_eop_cnt", eop_cyc.size() - eop0, 1);
    if (eop_cyc.size() > eop0)
      check("b2b_eop_gap", {31'h0, in_window(eop_cyc[eop0] - get_cyc(dr0 + 1), GAPC)}, 32'h1);
    check("b2b_fe", fe_cnt - fe0, 0);

    // Good byte, then a framing error with a long break
    snap();
    send_frame(8'h77, 1'b1);
    tick(C);
    send_frame(8'hFF, 1'b0);
    rx = 1'b0;
    tick(39 * C);
    rx = 1'b1;
    tick(6 * C);
    check("fe_dr_cnt", dr_cyc.size() - dr0, 1);
    check("fe_cnt", fe_cnt - fe0, 1);
    check("fe_eop", eop_cyc.size() - eop0, 0);
    check("fe_data", {24'h0, data}, 32'h77);
    check("fe_idle", {31'h0, idle}, 32'h1);

    // Short low glitch
    snap();
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(4 * C);
    check("gl_dr", dr_cyc.size() - dr0, 0);
    check("gl_fe", fe_cnt - fe0, 0);
    check("gl_eop", eop_cyc.size() - eop0, 0);
    check("gl_idle", {31'h0, idle}, 32'h1);

    // Start before the gap expires suppresses endofpacket
    snap();
    send_frame(8'h11, 1'b1);
    tick(3 * C);
    send_frame(8'h22, 1'b1);
    tick(6 * C);
    check("gap_cnt", dr_cyc.size() - dr0, 2);
    check("gap_d0", get_dat(dr0), 32'h11);
    check("gap_d1", get_dat(dr0 + 1), 32'h22);
    check("gap_eop_cnt", eop_cyc.size() - eop0, 1);
    if (eop_cyc.size() > eop0)
      check("gap_eop_time", {31'h0, in_window(eop_cyc[eop0] - get_cyc(dr0 + 1), GAPC)}, 32'h1);

    // Reset in the middle of a frame
    snap();
    b = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    rst_n = 1'b0;
    tick(2);
    check("mrst_data", {24'h0, data}, 32'h00);
    check("mrst_idle", {31'h0, idle}, 32'h1);
    rx = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(2 * C);
    check("mrst_dr", dr_cyc.size() - dr0, 0);
    check("mrst_fe", fe_cnt - fe0, 0);
    check("mrst_eop", eop_cyc.size() - eop0, 0);
    snap();
    send_frame(8'h81, 1'b1);
    tick(6 * C);
    check("post_cnt", dr_cyc.size() - dr0, 1);
    check("post_data", {24'h0, data}, 32'h81);
    check("post_eop", eop_cyc.size() - eop0, 1);

    // Randomized frame stream against the frame-level model
    snap();
    exp_fe    = 0;
    exp_eop   = 0;
    armed     = 1'b0;
    last_good = 8'h81;
    for (int f = 0; f < 40; f++) begin
      b   = 8'($urandom);
      err = ($urandom_range(0, 5) == 0);
      send_frame(b, !err);
      if (err) begin
        exp_fe++;
        armed = 1'b0;
        k = $urandom_range(0, 3);
        rx = 1'b0;
        tick(k * C);
      end else begin
        exp_q.push_back(b);
        last_good = b;
        armed = 1'b1;
      end
      g = gaps[$urandom_range(0, 5)];
      if (err && g == 0) g = 1;
      if (armed && g > EB) begin
        exp_eop++;
        armed = 1'b0;
      end
      rx = 1'b1;
      tick(g * C);
    end
    tick(6 * C);
    if (armed) exp_eop++;
    check("rnd_cnt", dr_cyc.size() - dr0, exp_q.size());
    foreach (exp_q[i]) check("rnd_data", get_dat(dr0 + i), {24'h0, exp_q[i]});
    check("rnd_fe", fe_cnt - fe0, exp_fe);
    check("rnd_eop", eop_cyc.size() - eop0, exp_eop);
    check("rnd_last", {24'h0, data}, {24'h0, last_good});
    check("rnd_idle", {31'h0, idle}, 32'h1);
    check("excl", excl_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per bit (50 MHz / 115200); legal values are 4 or more.
REQ-002 SHALL have parameter EOP_BITS, default 16, idle bit-times after the last good byte before end-of-packet.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port data  output  8  last correctly framed byte.
REQ-007 SHALL have port data_ready  output  1  one-cycle pulse; data valid in the same cycle.
REQ-008 SHALL have port frame_error  output  1  one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port endofpacket  output  1  one-cycle pulse after an idle gap that follows at least one good byte.
REQ-010 SHALL have port idle  output  1  high while the FSM is in IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-012 SHALL implement the states IDLE, START, DATA, STOP and BREAK.
REQ-013 IDLE: when rxs=0, SHALL enter START with the bit counter cleared.
REQ-014 START: SHALL sample rxs after CLKS_PER_BIT/2 cycles (integer divide).
- rxs=0: enter DATA.
- rxs=1: false start; return to IDLE with no output pulse.
REQ-015 DATA: SHALL sample rxs every CLKS_PER_BIT cycles, 8 samples, shifted in LSB first.
REQ-016 STOP: SHALL sample rxs CLKS_PER_BIT cycles after the 8th data sample.
- rxs=1: load data, pulse data_ready for 1 cycle, arm the EOP detector, go to IDLE.
- rxs=0: pulse frame_error for 1 cycle, leave data unchanged, go to BREAK.
REQ-017 BREAK: SHALL remain in BREAK until rxs=1, then go to IDLE; BREAK SHALL NOT start a frame.
REQ-018 data_ready and frame_error SHALL assert in the cycle after the stop-bit sample edge; data SHALL stay stable until the next data_ready.
REQ-019 The gap counter SHALL count clk cycles while armed, in IDLE and with rxs=1.
- It SHALL clear on any exit from IDLE.
- It SHALL saturate at EOP_BITS*CLKS_PER_BIT.
- On reaching that value it SHALL pulse endofpacket once and disarm.
REQ-020 A frame_error SHALL disarm the EOP detector without pulsing endofpacket.
REQ-021 A start bit that arrives before the gap expires SHALL clear the gap counter, keep the detector armed, and suppress endofpacket.
REQ-022 data_ready, frame_error and endofpacket SHALL be mutually exclusive in any cycle.
REQ-023 Counter widths SHALL be sized from the parameters with $clog2 so that no counter wraps.
REQ-024 Back-to-back frames (a start bit immediately after the stop-bit sample) SHALL be received without loss.
REQ-025 Nominal latency from rx falling edge to data_ready SHALL be 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, ±1 cycle for the synchronizer phase.

Reset
REQ-026 While rst_n=0, SHALL force state=IDLE, data=8'h00, data_ready=0, frame_error=0, endofpacket=0, idle=1, synchronizer flops=1, all counters=0 and the EOP detector disarmed.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no output pulse.
REQ-028 After reset release with rx held low, the block SHALL start a frame only after a falling edge, because the synchronizer resets to 1.

Verification (CLKS_PER_BIT=16, EOP_BITS=4)
REQ-029 Send 8'hA5 with a valid stop bit -> one data_ready pulse; data=8'hA5; latency 2+8+144+1 cycles ±1; frame_error=0.
REQ-030 Send 8'h3C then 8'hC3 back-to-back, then hold idle -> two data_ready pulses (3C then C3), then exactly one endofpacket 64 cycles after the second data_ready, ±1.
REQ-031 Send 8'hFF with stop bit=0, hold rx low 40 bit-times, then release -> one frame_error; data unchanged; no data_ready; no endofpacket; receiver idle.
REQ-032 Low glitch of 5 cycles on rx -> return to IDLE; no pulses on any output.
REQ-033 Send byte 8'h11, then start byte 8'h22 after 3 idle bit-times -> no endofpacket between the bytes; one endofpacket 64 cycles after the 8'h22 data_ready.
REQ-034 Assert rst_n=0 during DATA of 8'h5A, release, then send 8'h81 -> no pulse for the aborted frame; data=8'h81 after one data_ready.
